// File: rtl/spu_issue_scoreboard.sv
// spu_issue_scoreboard
//   Single-issue hazard scheduler in front of the SPU execution pipes.
//   A shift table S[0..MAX_LAT-1] tracks in-flight register writes. Each entry
//   is the write that reaches the register-file write port after it leaves S[0].
//   Issue is held on RAW, WAW or write-port (structural) hazards. The block
//   emits a one-hot unit start pulse and the registered write-back tag.
//
//   Optional feature macro: SCOREBOARD_STATS_EN
//     defined   : raw_cnt/waw_cnt/str_cnt count stall cycles by cause. They
//                 saturate, and stats_clr zeroes them.
//     undefined : the counters are tied to zero and stats_clr is ignored.
//
//   Handshake: an instruction is accepted ("fires") in the cycle where
//   issue_valid and issue_ready are both high. issue_ready is combinational
//   and does not depend on issue_valid. The upstream holds its instruction
//   until it fires, or withdraws it. No state changes when issue_valid is low.
//
//   There is no FSM. The table contents (slot_v/slot_rt) are the only state
//   besides the write-back register and the counters.

module spu_issue_scoreboard #(
  parameter int LAT_U0 = 2,  // simple fixed 1
  parameter int LAT_U1 = 4,  // simple fixed 2
  parameter int LAT_U2 = 4,  // byte
  parameter int LAT_U3 = 7   // single-precision FP; every latency must be >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_unit,
  input  logic [6:0]  ra_addr,
  input  logic [6:0]  rb_addr,
  input  logic [6:0]  rc_addr,
  input  logic        ra_use,
  input  logic        rb_use,
  input  logic        rc_use,
  input  logic [6:0]  rt_addr,
  input  logic        reg_write,
  input  logic        flush,
  output logic [3:0]  unit_go,
  output logic [1:0]  stall_cause,
  output logic        wb_valid,
  output logic [6:0]  wb_addr,
  input  logic        stats_clr,
  output logic [31:0] raw_cnt,
  output logic [31:0] waw_cnt,
  output logic [31:0] str_cnt
);

  localparam int NUM_UNITS = 4;
  localparam int MAX_01    = (LAT_U0 > LAT_U1) ? LAT_U0 : LAT_U1;
  localparam int MAX_23    = (LAT_U2 > LAT_U3) ? LAT_U2 : LAT_U3;
  localparam int MAX_LAT   = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_RAW    = 2'd1;
  localparam logic [1:0] CAUSE_WAW    = 2'd2;
  localparam logic [1:0] CAUSE_STRUCT = 2'd3;

  // Write-back slot table. slot_v[0]/slot_rt[0] is the write that drives the
  // write-back register at the next edge.
  logic [MAX_LAT-1:0] slot_v;
  logic [6:0]         slot_rt [MAX_LAT];

  int   sel_lat;
  logic raw_hz;
  logic waw_hz;
  logic str_hz;
  logic fire;
  logic alloc;

  // True when a source that is actually read names the given register.
  function automatic logic src_hit(input logic use_i, input logic [6:0] addr,
                                   input logic [6:0] rt);
    return use_i && (addr == rt);
  endfunction

  // Latency of the targeted pipe, in cycles from issue to S[0].
  always_comb begin
    sel_lat = LAT_U0;
    case (issue_unit)
      2'd0:    sel_lat = LAT_U0;
      2'd1:    sel_lat = LAT_U1;
      2'd2:    sel_lat = LAT_U2;
      default: sel_lat = LAT_U3;
    endcase
  end

  // Hazard detection against the table as it stands this cycle (pre-shift).
  // The new write would land in S[L-1] after the shift, which is the current
  // S[L]. An occupied S[L] therefore means two writes would reach the port
  // together. A same-register write at or beyond S[L] would retire after this
  // one and clobber it. Sources are compared only against older writes, so
  // an instruction that reads its own destination does not block itself.
  always_comb begin
    raw_hz = 1'b0;
    waw_hz = 1'b0;
    str_hz = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (slot_v[k]) begin
        if (src_hit(ra_use, ra_addr, slot_rt[k]) ||
            src_hit(rb_use, rb_addr, slot_rt[k]) ||
            src_hit(rc_use, rc_addr, slot_rt[k])) begin
          raw_hz = 1'b1;
        end
        if (reg_write && (k >= sel_lat) && (slot_rt[k] == rt_addr)) begin
          waw_hz = 1'b1;
        end
        if (reg_write && (k == sel_lat)) begin
          str_hz = 1'b1;
        end
      end
    end
    // The write being retired this cycle is not yet readable from the RF.
    if (wb_valid &&
        (src_hit(ra_use, ra_addr, wb_addr) ||
         src_hit(rb_use, rb_addr, wb_addr) ||
         src_hit(rc_use, rc_addr, wb_addr))) begin
      raw_hz = 1'b1;
    end
  end

  // Ready is withheld during flush and while reset is asserted. Holding it
  // low during reset keeps unit_go quiet during an asynchronous reset.
  always_comb begin
    issue_ready = ~reset & ~flush & ~raw_hz & ~waw_hz & ~str_hz;
    fire        = issue_valid & issue_ready;
    alloc       = fire & reg_write;
  end

  // One-hot start pulse to the targeted pipe.
  always_comb begin
    unit_go             = '0;
    unit_go[issue_unit] = fire;
  end

  // Stall reason, prioritised RAW > WAW > STRUCT. It is zero unless an
  // instruction is presented and held.
  always_comb begin
    stall_cause = CAUSE_NONE;
    if (issue_valid && !issue_ready) begin
      if (raw_hz)      stall_cause = CAUSE_RAW;
      else if (waw_hz) stall_cause = CAUSE_WAW;
      else if (str_hz) stall_cause = CAUSE_STRUCT;
      else             stall_cause = CAUSE_NONE;
    end
  end

  // Table shift toward S[0], with allocation of the fired write into S[L-1].
  // Flush clears every valid bit. Fire cannot coincide with flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_v <= '0;
      for (int k = 0; k < MAX_LAT; k++) begin
        slot_rt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < MAX_LAT - 1; k++) begin
        slot_v[k]  <= slot_v[k+1] & ~flush;
        slot_rt[k] <= slot_rt[k+1];
      end
      slot_v[MAX_LAT-1]  <= 1'b0;
      slot_rt[MAX_LAT-1] <= '0;
      for (int k = 0; k < MAX_LAT; k++) begin
        if (alloc && (k == sel_lat - 1)) begin
          slot_v[k]  <= 1'b1;
          slot_rt[k] <= rt_addr;
        end
      end
    end
  end

  // Register-file write port: S[0] retires into the write-back register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
    end else begin
      wb_valid <= slot_v[0] & ~flush;
      wb_addr  <= slot_rt[0];
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic count_en;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A stall cycle counts only when a held instruction is blocked by a hazard.
  // Flush cycles do not count.
  always_comb begin
    count_en = issue_valid & ~issue_ready & ~flush;
  end

  // Saturating stall counters. Clear takes priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_cnt <= '0;
      waw_cnt <= '0;
      str_cnt <= '0;
    end else if (stats_clr) begin
      raw_cnt <= '0;
      waw_cnt <= '0;
      str_cnt <= '0;
    end else if (count_en) begin
      case (stall_cause)
        CAUSE_RAW:    raw_cnt <= sat_inc(raw_cnt);
        CAUSE_WAW:    waw_cnt <= sat_inc(waw_cnt);
        CAUSE_STRUCT: str_cnt <= sat_inc(str_cnt);
        default:      ;
      endcase
    end
  end
`else
  logic unused_stats_clr;

  assign raw_cnt          = '0;
  assign waw_cnt          = '0;
  assign str_cnt          = '0;
  assign unused_stats_clr = stats_clr;
`endif

  logic [31:0] unused_num_units;
  assign unused_num_units = NUM_UNITS;

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Testbench for spu_issue_scoreboard.
// The reference model keeps the list of in-flight writes with the cycle in
// which each appears on the write-back port. Every hazard is derived from
// that list:
//   RAW    - a used source names a write whose write-back cycle is now or later
//   WAW    - the same register is already due at or after the new write's cycle
//   STRUCT - another write is already due in the new write's cycle
// SCOREBOARD_STATS_EN selects the expected counter behaviour.

module tb_spu_issue_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_unit;
  logic [6:0]  ra_addr, rb_addr, rc_addr;
  logic        ra_use, rb_use, rc_use;
  logic [6:0]  rt_addr;
  logic        reg_write;
  logic        flush;
  logic [3:0]  unit_go;
  logic [1:0]  stall_cause;
  logic        wb_valid;
  logic [6:0]  wb_addr;
  logic        stats_clr;
  logic [31:0] raw_cnt, waw_cnt, str_cnt;

  spu_issue_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_unit  (issue_unit),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .rc_addr     (rc_addr),
    .ra_use      (ra_use),
    .rb_use      (rb_use),
    .rc_use      (rc_use),
    .rt_addr     (rt_addr),
    .reg_write   (reg_write),
    .flush       (flush),
    .unit_go     (unit_go),
    .stall_cause (stall_cause),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .stats_clr   (stats_clr),
    .raw_cnt     (raw_cnt),
    .waw_cnt     (waw_cnt),
    .str_cnt     (str_cnt)
  );

`ifdef SCOREBOARD_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [6:0] rt;
    int         done;  // cycle in which wb_valid shows this write
  } wr_t;

  wr_t         recs[$];
  int          n;  // current cycle index
  logic [31:0] m_raw, m_waw, m_str;

  int checks;
  int errors;

  // Values seen in the most recent step (DUT) plus the model's fire decision
  logic        obs_rdy, obs_wbv, exp_fire;
  logic [1:0]  obs_cause;
  logic [3:0]  obs_go;
  logic [6:0]  obs_wba;
  logic [31:0] obs_raw, obs_waw, obs_str;

  function automatic int lat_of(input logic [1:0] u);
    case (u)
      2'd0:    return 2;
      2'd1:    return 4;
      2'd2:    return 4;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic set_idle();
    issue_valid = 1'b0; issue_unit = 2'd0;
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    ra_use = 1'b0; rb_use = 1'b0; rc_use = 1'b0;
    rt_addr = '0; reg_write = 1'b0; flush = 1'b0; stats_clr = 1'b0;
  endtask

  task automatic model_clear();
    recs.delete();
    m_raw = '0; m_waw = '0; m_str = '0;
  endtask

  // One clock cycle: inputs are already driven. Sample at the falling edge,
  // compare against the model, advance the model, then cross the rising edge.
  task automatic step();
    logic raw_e, waw_e, str_e, rdy_e, wbv_e;
    logic [1:0] cause_e;
    logic [3:0] go_e;
    logic [6:0] wba_e;
    int lat;
    wr_t keep[$];
    @(negedge clk);
    lat = lat_of(issue_unit);
    raw_e = 1'b0; waw_e = 1'b0; str_e = 1'b0; wbv_e = 1'b0; wba_e = '0;
    foreach (recs[i]) begin
      if (recs[i].done == n) begin
        wbv_e = 1'b1;
        wba_e = recs[i].rt;
      end
      if (recs[i].done >= n) begin
        if ((ra_use && ra_addr == recs[i].rt) || (rb_use && rb_addr == recs[i].rt) ||
            (rc_use && rc_addr == recs[i].rt)) raw_e = 1'b1;
      end
      if (reg_write && recs[i].done >= n + lat + 1 && recs[i].rt == rt_addr) waw_e = 1'b1;
      if (reg_write && recs[i].done == n + lat + 1) str_e = 1'b1;
    end
    rdy_e   = !flush && !raw_e && !waw_e && !str_e;
    cause_e = 2'd0;
    if (issue_valid && !rdy_e) cause_e = raw_e ? 2'd1 : waw_e ? 2'd2 : str_e ? 2'd3 : 2'd0;
    exp_fire = issue_valid && rdy_e;
    go_e = exp_fire ? (4'b0001 << issue_unit) : 4'b0000;

    obs_rdy = issue_ready; obs_cause = stall_cause; obs_go = unit_go;
    obs_wbv = wb_valid; obs_wba = wb_addr;
    obs_raw = raw_cnt; obs_waw = waw_cnt; obs_str = str_cnt;

    check("ready", {31'd0, obs_rdy}, {31'd0, rdy_e});
    check("stall_cause", {30'd0, obs_cause}, {30'd0, cause_e});
    check("unit_go", {28'd0, obs_go}, {28'd0, go_e});
    check("wb_valid", {31'd0, obs_wbv}, {31'd0, wbv_e});
    if (wbv_e) check("wb_addr", {25'd0, obs_wba}, {25'd0, wba_e});
    check("raw_cnt", obs_raw, STATS_EN ? m_raw : 32'd0);
    check("waw_cnt", obs_waw, STATS_EN ? m_waw : 32'd0);
    check("str_cnt", obs_str, STATS_EN ? m_str : 32'd0);

    // Model update for the coming edge
    foreach (recs[i]) begin
      if (recs[i].done > n && !(flush && recs[i].done >= n + 1)) keep.push_back(recs[i]);
    end
    recs = keep;
    if (exp_fire && reg_write) recs.push_back('{rt: rt_addr, done: n + lat + 1});
    if (stats_clr) begin
      m_raw = '0; m_waw = '0; m_str = '0;
    end else if (issue_valid && !rdy_e && !flush) begin
      if (cause_e == 2'd1 && m_raw != 32'hFFFF_FFFF) m_raw++;
      if (cause_e == 2'd2 && m_waw != 32'hFFFF_FFFF) m_waw++;
      if (cause_e == 2'd3 && m_str != 32'hFFFF_FFFF) m_str++;
    end
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic drain(input int cycles);
    set_idle();
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    int fire_c, stalls;
    logic fired;
    checks = 0; errors = 0; n = 0;
    model_clear();
    set_idle();

    // Reset state
    reset = 1'b1;
    #1;
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_addr", {25'd0, wb_addr}, 32'd0);
    check("rst_ready", {31'd0, issue_ready}, 32'd0);
    check("rst_raw_cnt", raw_cnt, 32'd0);
    check("rst_str_cnt", str_cnt, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // T1 latency: U1 rt=5 fires in cycle 0, write-back in cycle 5 only
    issue_valid = 1'b1; issue_unit = 2'd1; rt_addr = 7'd5; reg_write = 1'b1;
    step();
    check("t1_unit_go", {28'd0, obs_go}, 32'h2);
    set_idle();
    for (int c = 1; c <= 6; c++) begin
      step();
      check("t1_wb_valid", {31'd0, obs_wbv}, {31'd0, c == 5});
      if (c == 5) check("t1_wb_addr", {25'd0, obs_wba}, 32'd5);
    end
    drain(2);

    // T2 RAW: U1 rt=5, then U0 reading ra=5 stalls cycles 1..5 and fires in 6
    issue_valid = 1'b1; issue_unit = 2'd1; rt_addr = 7'd5; reg_write = 1'b1;
    step();
    set_idle();
    issue_valid = 1'b1; issue_unit = 2'd0; ra_addr = 7'd5; ra_use = 1'b1;
    rt_addr = 7'd6; reg_write = 1'b1;
    fired = 1'b0; fire_c = -1; stalls = 0;
    for (int c = 1; c <= 20 && !fired; c++) begin
      step();
      if (obs_rdy && fire_c < 0) fire_c = c;
      if (obs_cause == 2'd1) stalls++;
      fired = exp_fire;
    end
    check("t2_fire_cycle", fire_c, 32'd6);
    check("t2_raw_stalls", stalls, 32'd5);
    drain(10);

    // T3 STRUCT: U1 rt=3 at 0, U0 rt=4 at 2 collides on the write port
    issue_valid = 1'b1; issue_unit = 2'd1; rt_addr = 7'd3; reg_write = 1'b1;
    step();
    set_idle();
    step();
    issue_valid = 1'b1; issue_unit = 2'd0; rt_addr = 7'd4; reg_write = 1'b1;
    step();
    check("t3_cause_c2", {30'd0, obs_cause}, 32'd3);
    step();
    check("t3_ready_c3", {31'd0, obs_rdy}, 32'd1);
    set_idle();
    step();
    step();
    check("t3_wb_c5", {24'd0, obs_wbv, obs_wba}, {24'd0, 1'b1, 7'd3});
    step();
    check("t3_wb_c6", {24'd0, obs_wbv, obs_wba}, {24'd0, 1'b1, 7'd4});
    drain(10);

    // Stall counters after T2+T3, then clear
    check("t6_raw_cnt", obs_raw, STATS_EN ? 32'd5 : 32'd0);
    check("t6_str_cnt", obs_str, STATS_EN ? 32'd1 : 32'd0);
    check("t6_waw_cnt", obs_waw, 32'd0);
    stats_clr = 1'b1;
    step();
    set_idle();
    step();
    check("t6_clr_raw", obs_raw, 32'd0);
    check("t6_clr_str", obs_str, 32'd0);

    // T4 WAW: U3 rt=9 at 0, U0 rt=9 stalls 1..5, fires 6, write-backs at 8 and 9
    issue_valid = 1'b1; issue_unit = 2'd3; rt_addr = 7'd9; reg_write = 1'b1;
    step();
    issue_unit = 2'd0;
    fired = 1'b0; fire_c = -1; stalls = 0;
    for (int c = 1; c <= 20 && !fired; c++) begin
      step();
      if (obs_rdy && fire_c < 0) fire_c = c;
      if (obs_cause == 2'd2) stalls++;
      fired = exp_fire;
    end
    check("t4_fire_cycle", fire_c, 32'd6);
    check("t4_waw_stalls", stalls, 32'd5);
    set_idle();
    for (int c = 7; c <= 10; c++) begin
      step();
      check("t4_wb_valid", {31'd0, obs_wbv}, {31'd0, (c == 8) || (c == 9)});
      if (c == 8 || c == 9) check("t4_wb_addr", {25'd0, obs_wba}, 32'd9);
    end
    drain(4);

    // T5 flush: U3 rt=7 at 0, flush at 2, ra=7 issues at 3, 7 never written back
    issue_valid = 1'b1; issue_unit = 2'd3; rt_addr = 7'd7; reg_write = 1'b1;
    step();
    set_idle();
    step();
    flush = 1'b1;
    step();
    check("t5_flush_ready", {31'd0, obs_rdy}, 32'd0);
    set_idle();
    issue_valid = 1'b1; issue_unit = 2'd0; ra_addr = 7'd7; ra_use = 1'b1;
    rt_addr = 7'd10; reg_write = 1'b1;
    step();
    check("t5_ready_c3", {31'd0, obs_rdy}, 32'd1);
    set_idle();
    for (int c = 0; c < 10; c++) begin
      step();
      check("t5_no_wb7", {31'd0, obs_wbv && obs_wba == 7'd7}, 32'd0);
    end

    // T5 with reset pulsed mid-flight in cycle 2
    issue_valid = 1'b1; issue_unit = 2'd3; rt_addr = 7'd7; reg_write = 1'b1;
    step();
    set_idle();
    step();
    issue_valid = 1'b1; issue_unit = 2'd0; rt_addr = 7'd8; reg_write = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t5r_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("t5r_wb_addr", {25'd0, wb_addr}, 32'd0);
    check("t5r_ready", {31'd0, issue_ready}, 32'd0);
    check("t5r_unit_go", {28'd0, unit_go}, 32'd0);
    check("t5r_waw_cnt", waw_cnt, 32'd0);
    set_idle();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n = n + 1;
    model_clear();
    for (int c = 0; c < 10; c++) begin
      step();
      check("t5r_no_wb", {31'd0, obs_wbv}, 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      set_idle();
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_unit  = 2'($urandom_range(0, 3));
      ra_addr = 7'($urandom_range(0, 7)); ra_use = 1'($urandom_range(0, 1));
      rb_addr = 7'($urandom_range(0, 7)); rb_use = ($urandom_range(0, 3) == 0);
      rc_addr = 7'($urandom_range(0, 7)); rc_use = ($urandom_range(0, 5) == 0);
      rt_addr = 7'($urandom_range(0, 7));
      reg_write = ($urandom_range(0, 4) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      stats_clr = ($urandom_range(0, 59) == 0);
      step();
    end
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
